// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage with a decoupled, in-order fetch queue. Word fetches
// go to instruction memory over a req/gnt handshake. Responses come back
// in order on rvalid, after a variable latency. Each returned instruction is
// queued together with its PC. The queue head is presented to the IF/ID
// register and advances under IFWrite.
//
// A taken Branch or a Jump (a "redirect") does four things:
//   - flushes the queue,
//   - marks every request still in flight as "to be dropped",
//   - restarts fetch at JumpAddr (word aligned),
//   - raises IF_flush in the same cycle.
//
// Parameters
//   XLEN      PC / address width
//   RESET_PC  first fetch address after reset
//   FQ_DEPTH  queue entries (power of two, >= 2); also caps outstanding fetches
//   NOP_INSN  instruction presented when the queue is empty
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   Branch, Jump      redirect requests from EX (either one redirects)
//   JumpAddr          redirect target
//   IFWrite           1: consume head entry this cycle, 0: stall
//   imem_req/addr     fetch request and word-aligned address
//   imem_gnt          request accepted this cycle
//   imem_rvalid/rdata in-order fetch response
//   Instruction_if    head instruction, or NOP_INSN when empty
//   PC                head PC, or the current fetch PC when empty
//   IF_valid          Instruction_if/PC carry a real fetched instruction
//   IF_flush          flush the IF/ID register this cycle
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4,
  parameter logic [31:0]     NOP_INSN = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Branch,
  input  logic            Jump,
  input  logic [XLEN-1:0] JumpAddr,
  input  logic            IFWrite,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     Instruction_if,
  output logic [XLEN-1:0] PC,
  output logic            IF_valid,
  output logic            IF_flush
);

  localparam int              CW         = $clog2(FQ_DEPTH + 1);
  localparam int              PW         = $clog2(FQ_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [CW:0]     DEPTH_EXT  = (CW + 1)'(FQ_DEPTH);
  localparam logic [CW-1:0]   DEPTH_CNT  = CW'(FQ_DEPTH);

  // Fetch address generator state.
  logic [XLEN-1:0] fetch_pc;

  // Fetch queue: PC and instruction per entry.
  logic [XLEN-1:0] q_pc   [FQ_DEPTH];
  logic [31:0]     q_insn [FQ_DEPTH];
  logic [PW-1:0]   q_rd;
  logic [PW-1:0]   q_wr;
  logic [CW-1:0]   q_cnt;

  // PCs of requests that are granted but have not returned. Requests that
  // will be dropped are not kept here, because a redirect clears this FIFO.
  logic [XLEN-1:0] pend_pc [FQ_DEPTH];
  logic [PW-1:0]   pend_rd;
  logic [PW-1:0]   pend_wr;

  // out_cnt counts every request in flight, including ones to be dropped.
  // drop_cnt counts the responses to discard: the oldest drop_cnt of them.
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   drop_cnt;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            credit_ok;
  logic            issue;
  logic            drop_rsp;
  logic            push;
  logic            pop;
  logic [CW-1:0]   out_cnt_next;

  // ---- control decode -------------------------------------------------------
  always_comb begin
    redirect    = Branch | Jump;
    redirect_pc = JumpAddr & ALIGN_MASK;

    // Issue only when every outstanding response already has a queue slot.
    // This is why a push can never meet a full queue.
    credit_ok   = ({1'b0, q_cnt} + {1'b0, out_cnt}) < DEPTH_EXT;
    imem_req    = credit_ok & ~redirect;
    imem_addr   = fetch_pc & ALIGN_MASK;
    issue       = imem_req & imem_gnt;

    // A response that arrives during a redirect is stale as well. It is
    // discarded here and is not added to drop_cnt.
    drop_rsp    = imem_rvalid & ((drop_cnt != '0) | redirect);
    push        = imem_rvalid & ~drop_rsp;

    IF_valid    = (q_cnt != '0);
    pop         = IFWrite & IF_valid & ~redirect;
    IF_flush    = redirect;

    out_cnt_next = out_cnt + CW'(issue) - CW'(imem_rvalid);

    Instruction_if = IF_valid ? q_insn[q_rd] : NOP_INSN;
    PC             = IF_valid ? q_pc[q_rd]   : fetch_pc;
  end

  // ---- fetch PC and outstanding-request bookkeeping -------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC & ALIGN_MASK;
      out_cnt  <= '0;
      drop_cnt <= '0;
      pend_rd  <= '0;
      pend_wr  <= '0;
    end else begin
      out_cnt <= out_cnt_next;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= out_cnt_next;
        pend_rd  <= '0;
        pend_wr  <= '0;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          pend_wr  <= pend_wr + 1'b1;
        end
        if (imem_rvalid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
        if (push) begin
          pend_rd <= pend_rd + 1'b1;
        end
      end
    end
  end

  // Pending-PC storage. It holds data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      pend_pc[pend_wr] <= fetch_pc;
    end
  end

  // ---- fetch queue control --------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else if (redirect) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (push) begin
        q_wr <= q_wr + 1'b1;
      end
      if (pop) begin
        q_rd <= q_rd + 1'b1;
      end
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
    end
  end

  // Queue payload. It holds data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[q_wr]   <= pend_pc[pend_rd];
      q_insn[q_wr] <= imem_rdata;
    end
  end

  // ---- invariants -----------------------------------------------------------
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    push |-> (q_cnt < DEPTH_CNT))
    else $error("fetch queue overflow");

  a_out_bound : assert property (@(posedge clk) disable iff (!reset)
    (out_cnt <= DEPTH_CNT) && (drop_cnt <= out_cnt))
    else $error("outstanding counter out of range");

  a_rsp_expected : assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> (out_cnt != '0))
    else $error("response without outstanding request");

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a decoupled fetch queue. It issues word fetches to instruction memory over a req/gnt + rvalid interface that tolerates variable latency, buffers returned instructions with their PCs in an in-order queue, and presents them to the IF/ID register under `IFWrite` stall control. Branch/jump redirects flush the queue, discard in-flight responses and restart fetch at `JumpAddr`. It sits between instruction memory and the IF/ID pipeline register.

## Interface
- `XLEN`, 32, PC/address width
- `RESET_PC`, 0, first fetch address after reset
- `FQ_DEPTH`, 4, fetch-queue entries; power of two, ≥2; also bounds outstanding requests
- `NOP_INSN`, 32'h00000013, value driven on `Instruction_if` when no valid entry
- `clk` in 1 — single clock, all state on rising edge
- `reset` in 1 — asynchronous, active-low
- `Branch` in 1 — taken-branch redirect from EX
- `Jump` in 1 — jump redirect from EX
- `JumpAddr` in XLEN — redirect target for `Branch` or `Jump`
- `IFWrite` in 1 — 1: consume head entry this cycle; 0: stall (hold outputs)
- `imem_req` out 1 — fetch request valid
- `imem_addr` out XLEN — word-aligned fetch address
- `imem_gnt` in 1 — request accepted this cycle
- `imem_rvalid` in 1 — response valid; responses return in request order
- `imem_rdata` in 32 — instruction word
- `Instruction_if` out 32 — head instruction, or `NOP_INSN`
- `PC` out XLEN — head PC, or current fetch PC when queue empty
- `IF_valid` out 1 — `Instruction_if`/`PC` hold a real fetched instruction
- `IF_flush` out 1 — flush IF/ID this cycle

## Operation
- State: `fetch_pc`, queue (FQ_DEPTH × {XLEN pc, 32 insn}, rd/wr pointers, count), `out_cnt` (issued, not returned, incl. to-be-dropped), `drop_cnt` (responses to discard). Counters are `$clog2(FQ_DEPTH+1)` bits.
- `redirect = Branch | Jump`; both use `JumpAddr`. `IF_flush = redirect` (combinational).
- Issue: `imem_req = (count + out_cnt < FQ_DEPTH) & ~redirect`; `imem_addr = {fetch_pc[XLEN-1:2], 2'b00}`. On `imem_req & imem_gnt`: `fetch_pc += 4`, `out_cnt += 1`. Address is stable while `imem_req` is held; req is withdrawn only by redirect.
- Response: on `imem_rvalid`, `out_cnt -= 1`. If `drop_cnt > 0` (or redirect this cycle): discard; else push {pc of oldest request, `imem_rdata`}. The PC of each outstanding request is tracked in a FQ_DEPTH-deep in-order PC FIFO.
- The credit rule guarantees a push never meets a full queue; overflow is unreachable and is flagged by an assertion.
- Pop: `IFWrite & IF_valid & ~redirect` advances the head.
- Redirect cycle: queue cleared, pop and push suppressed, `fetch_pc ← {JumpAddr[XLEN-1:2],2'b00}`, `drop_cnt ← out_cnt_next` (all outstanding after this cycle's rvalid decrement), pending-PC FIFO cleared.
- Dropped responses decrement `drop_cnt` and `out_cnt` together; new fetches issued after the redirect are never dropped.
- Outputs: `IF_valid = count != 0`; `Instruction_if`/`PC` from head, else `NOP_INSN`/`fetch_pc`.

## Timing
- Reset (async assert, sync-safe release): `fetch_pc = RESET_PC`, queue empty, `out_cnt = drop_cnt = 0`. Outputs: `imem_req = 1` (when redirect low), `imem_addr = RESET_PC`, `IF_valid = 0`, `Instruction_if = NOP_INSN`, `PC = RESET_PC`. `IF_flush` follows inputs.
- Reset asserted mid-operation: all state returns to the reset values immediately. Responses to pre-reset requests must not arrive after release; this is the memory's responsibility.
- Fetch latency: gnt in cycle t, rvalid in cycle r ≥ t+1. The entry is visible (`IF_valid`) at r+1.
- Redirect in cycle t: `imem_req = 0` in t. `imem_addr = JumpAddr` with req in t+1. `IF_valid = 0` from t+1 until the first new response is queued.
- Simultaneous: redirect + rvalid → response dropped, not counted into `drop_cnt`. Redirect + stale gnt is impossible (req gated). Push + pop on the same cycle → count unchanged. Back-to-back redirects → latest `JumpAddr` wins; `drop_cnt` accumulates via `out_cnt`.
- Peak throughput: one instruction per cycle with single-cycle memory and `IFWrite = 1`.

## Test plan
- Reset, zero-wait memory (gnt = 1, rvalid the next cycle), `IFWrite = 1` → `imem_addr` 0,4,8,…; `IF_valid` rises at cycle 2; `PC` = 0,4,8 on consecutive cycles; `Instruction_if` matches memory.
- Hold `IFWrite = 0` with FQ_DEPTH = 4 → exactly 4 grants, then `imem_req = 0`. Outputs frozen at `PC = 0`. Release → 0,4,8,12 drain, then fetch resumes at 16.
- 3-cycle memory latency, 3 outstanding; pulse `Jump`, `JumpAddr = 0x100` → `IF_flush = 1` for that cycle. The 3 old responses are discarded. The first `IF_valid` shows `PC = 0x100`.
- `Branch` in the same cycle as `imem_rvalid` and `IFWrite` → no push, no pop, queue empty next cycle. Next request address is `0x200` (target).
- Random gnt/rvalid stalls, random `IFWrite`, random redirects with a golden PC-sequence model → sequence matches; no overflow assertion fires; `out_cnt` never exceeds FQ_DEPTH.
- Assert `reset` low mid-burst → outputs at reset values the same cycle. After release, fetch restarts at `RESET_PC`.
